// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants and decoder state type
package seg7_pkg;

    // Active-low patterns, bit 6 = g ... bit 0 = a, indexed by digit value.
    localparam logic [6:0] SEG7_DIGIT [0:7] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78
    };

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic {
        S_TRACK,
        S_LOCKED
    } seg7_state_e;

endpackage

// File: rtl/seg7_pat_decode.sv
// rtl/seg7_pat_decode.sv - combinational 7-segment pattern to 3-bit value lookup
module seg7_pat_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic       legal,
    output logic       blank,
    output logic [2:0] bin
);

    // Match the pattern against every legal digit code.
    always_comb begin
        legal = 1'b0;
        bin   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pat == SEG7_DIGIT[i]) begin
                legal = 1'b1;
                bin   = 3'(i);
            end
        end
    end

    assign blank = (pat == SEG7_BLANK);

endmodule

// File: rtl/seg7_to_bit_3.sv
// rtl/seg7_to_bit_3.sv - debounced 7-segment decoder with one-slot valid/ready output (SEG7_DEC_ERRCNT_EN enables err_cnt)
module seg7_to_bit_3
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg7_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          binary_out,
    output logic                out_err,
    output logic                drop,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  in_q;
    logic [6:0]  cand;
    logic [6:0]  cand_nxt;
    logic [6:0]  lock_pat;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        chg;
    logic        reached;
    logic        episode;
    logic        emit;
    seg7_state_e state;
    seg7_state_e state_nxt;
    logic        dec_legal;
    logic        dec_blank;
    logic [2:0]  dec_bin;

    assign chg      = (in_q != cand);
    assign cand_nxt = chg ? in_q : cand;
    assign cnt_nxt  = chg ? 8'd1 : ((cnt == STABLE) ? cnt : cnt + 8'd1);
    // "Becomes" rather than "equals": a saturated count must not fire again.
    assign reached  = (cnt_nxt == STABLE) && (chg || (cnt != STABLE));

    // Decoding the next candidate lets STABLE_CYCLES=1 lock on the change edge;
    // for longer windows it is identical to cand whenever reached is set.
    seg7_pat_decode u_dec (
        .pat   (cand_nxt),
        .legal (dec_legal),
        .blank (dec_blank),
        .bin   (dec_bin)
    );

    // Register the raw bus and track how long the current candidate has held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q     <= SEG7_BLANK;
            cand     <= SEG7_BLANK;
            cnt      <= 8'd0;
            state    <= S_LOCKED;
            lock_pat <= SEG7_BLANK;
        end else begin
            in_q  <= seg7_in;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            state <= state_nxt;
            if (episode) begin
                lock_pat <= cand_nxt;
            end
        end
    end

    // Lock onto each stable episode once; a change while locked resumes tracking.
    always_comb begin
        state_nxt = state;
        episode   = 1'b0;
        case (state)
            S_TRACK: begin
                if (reached) begin
                    state_nxt = S_LOCKED;
                    episode   = 1'b1;
                end
            end
            S_LOCKED: begin
                if (chg) begin
                    if (reached) begin
                        episode = 1'b1;
                    end else begin
                        state_nxt = S_TRACK;
                    end
                end
            end
        endcase
    end

    // A glitch that returns to the last locked pattern is not a new episode.
    assign emit = episode && (cand_nxt != lock_pat) && !dec_blank;

    // One-entry output slot; a result arriving while it is still held is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            binary_out <= 3'd0;
            out_err    <= 1'b0;
            drop       <= 1'b0;
        end else if (emit) begin
            if (!out_valid || out_ready) begin
                out_valid  <= 1'b1;
                binary_out <= dec_legal ? dec_bin : 3'd0;
                out_err    <= !dec_legal;
            end else begin
                drop <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SEG7_DEC_ERRCNT_EN
    // Count every invalid emission, dropped or not, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (emit && !dec_legal && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
